// File: rtl/dcache_pkg.sv
// Shared types and helpers for the data-cache data array: store sizes,
// refill sequencer states and the store byte-lane mask.
package dcache_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_TRI  = 2'b11
  } st_size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_FILL = 2'b01,
    S_DONE = 2'b10
  } fill_state_e;

  // Lanes shifted past lane 3 fall off the 4-bit result; they never wrap.
  function automatic logic [3:0] byte_mask(input logic [1:0] size,
                                           input logic [1:0] pos);
    logic [3:0] base;
    case (size)
      SZ_BYTE: base = 4'b0001;
      SZ_HALF: base = 4'b0011;
      SZ_TRI:  base = 4'b0111;
      default: base = 4'b1111;
    endcase
    if (size == SZ_WORD) return 4'b1111;
    return base << pos;
  endfunction

endpackage

// File: rtl/dcache_way_ram.sv
// One cache way: word array with synchronous read and 4-lane byte-enable write.
// Read returns the pre-write contents; the top merges same-cycle writes.
module dcache_way_ram
  import dcache_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [31:0]          rdata,
  input  logic [3:0]           we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [31:0]          wdata
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/dcache_data_bank.sv
// Multi-way dcache data array: registered all-way read with write-first bypass,
// byte-masked store port, and a line-refill sequencer fed by the bus adapter.
module dcache_data_bank
  import dcache_pkg::*;
#(
  parameter int NUM_WAYS       = 2,
  parameter int SET_BITS       = 7,
  parameter int WORDS_PER_LINE = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int WAY_BITS       = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  parameter int OFF_BITS       = $clog2(WORDS_PER_LINE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en,
  input  logic [SET_BITS-1:0]      rd_set,
  input  logic [OFF_BITS-1:0]      rd_offset,
  output logic                     rd_valid,
  output logic [NUM_WAYS*32-1:0]   rd_data,
  input  logic                     st_en,
  output logic                     st_ready,
  input  logic [WAY_BITS-1:0]      st_way,
  input  logic [SET_BITS-1:0]      st_set,
  input  logic [OFF_BITS-1:0]      st_offset,
  input  logic [1:0]               st_size,
  input  logic [1:0]               st_bytepos,
  input  logic [31:0]              st_data,
  input  logic                     fill_start,
  input  logic [WAY_BITS-1:0]      fill_way,
  input  logic [SET_BITS-1:0]      fill_set,
  output logic                     fill_ready,
  input  logic                     fill_wvalid,
  input  logic [31:0]              fill_wdata,
  input  logic                     fill_wlast,
  output logic                     fill_busy,
  output logic                     fill_done,
  output logic                     fill_err
);

  localparam int ADDR_BITS = SET_BITS + OFF_BITS;

  fill_state_e         state_q, state_d;
  logic [OFF_BITS-1:0] cnt_q, cnt_d;
  logic [WAY_BITS-1:0] fway_q, fway_d;
  logic [SET_BITS-1:0] fset_q, fset_d;
  logic                err_q, err_d;

  logic                 last_beat;
  logic                 fill_beat;
  logic                 st_fire;
  logic [WAY_BITS-1:0]  wr_way;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [31:0]          wr_data;
  logic [3:0]           wr_mask;
  logic [ADDR_BITS-1:0] rd_addr;

  logic [3:0]  way_we    [NUM_WAYS];
  logic [31:0] ram_rdata [NUM_WAYS];
  logic [3:0]  byp_mask_q [NUM_WAYS];
  logic [31:0] byp_data_q;

  assign rd_addr    = {rd_set, rd_offset};
  assign last_beat  = (cnt_q == OFF_BITS'(WORDS_PER_LINE - 1));
  assign fill_beat  = (state_q == S_FILL) && fill_wvalid;
  assign fill_ready = (state_q == S_FILL);
  assign fill_busy  = (state_q != S_IDLE);
  assign fill_done  = (state_q == S_DONE);
  assign fill_err   = (state_q == S_DONE) && err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fway_q  <= '0;
      fset_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fway_q  <= fway_d;
      fset_q  <= fset_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fway_d  = fway_q;
    fset_d  = fset_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (fill_start) begin
          fway_d  = fill_way;
          fset_d  = fill_set;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (fill_wvalid) begin
          cnt_d = cnt_q + 1'b1;
          if (fill_wlast != last_beat) err_d = 1'b1;
          if (last_beat) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Refill beats own the single write port; stores yield to them and are
  // held off entirely for the line being refilled.
  always_comb begin
    st_ready = 1'b1;
    if (state_q != S_IDLE) begin
      if (st_set == fset_q && st_way == fway_q) st_ready = 1'b0;
      else if (fill_wvalid)                     st_ready = 1'b0;
    end
  end

  assign st_fire = st_en && st_ready;

  always_comb begin
    wr_way  = '0;
    wr_addr = '0;
    wr_data = '0;
    wr_mask = '0;
    if (fill_beat) begin
      wr_way  = fway_q;
      wr_addr = {fset_q, cnt_q};
      wr_data = fill_wdata;
      wr_mask = 4'b1111;
    end else if (st_fire) begin
      wr_way  = st_way;
      wr_addr = {st_set, st_offset};
      wr_data = st_data;
      wr_mask = byte_mask(st_size, st_bytepos);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid   <= 1'b0;
      byp_data_q <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) byp_data_q <= wr_data;
    end
  end

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    assign way_we[w] = (wr_way == WAY_BITS'(w)) ? wr_mask : '0;

    dcache_way_ram #(
      .ADDR_BITS (ADDR_BITS)
    ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .re    (rd_en),
      .raddr (rd_addr),
      .rdata (ram_rdata[w]),
      .we    (way_we[w]),
      .waddr (wr_addr),
      .wdata (wr_data)
    );

    // Remember which lanes were written at the read address in the read cycle.
    always_ff @(posedge clk) begin
      if (rst) begin
        byp_mask_q[w] <= '0;
      end else if (rd_en) begin
        byp_mask_q[w] <= (wr_addr == rd_addr) ? way_we[w] : '0;
      end
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
      assign rd_data[w*32 + 8*i +: 8] = byp_mask_q[w][i] ? byp_data_q[8*i +: 8]
                                                          : ram_rdata[w][8*i +: 8];
    end
  end

endmodule

// File: tb/tb_dcache_data_bank.sv
// Directed bench for dcache_data_bank (2 ways, 128 sets, 8 words per line).
module tb_dcache_data_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en;
  logic [6:0]  rd_set;
  logic [2:0]  rd_offset;
  logic        rd_valid;
  logic [63:0] rd_data;
  logic        st_en;
  logic        st_ready;
  logic [0:0]  st_way;
  logic [6:0]  st_set;
  logic [2:0]  st_offset;
  logic [1:0]  st_size;
  logic [1:0]  st_bytepos;
  logic [31:0] st_data;
  logic        fill_start;
  logic [0:0]  fill_way;
  logic [6:0]  fill_set;
  logic        fill_ready;
  logic        fill_wvalid;
  logic [31:0] fill_wdata;
  logic        fill_wlast;
  logic        fill_busy;
  logic        fill_done;
  logic        fill_err;

  int total = 0;
  int bad   = 0;

  dcache_data_bank #(
    .NUM_WAYS       (2),
    .SET_BITS       (7),
    .WORDS_PER_LINE (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .rd_set      (rd_set),
    .rd_offset   (rd_offset),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .st_en       (st_en),
    .st_ready    (st_ready),
    .st_way      (st_way),
    .st_set      (st_set),
    .st_offset   (st_offset),
    .st_size     (st_size),
    .st_bytepos  (st_bytepos),
    .st_data     (st_data),
    .fill_start  (fill_start),
    .fill_way    (fill_way),
    .fill_set    (fill_set),
    .fill_ready  (fill_ready),
    .fill_wvalid (fill_wvalid),
    .fill_wdata  (fill_wdata),
    .fill_wlast  (fill_wlast),
    .fill_busy   (fill_busy),
    .fill_done   (fill_done),
    .fill_err    (fill_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic set_store(input logic [0:0] w, input logic [6:0] s, input logic [2:0] o,
                           input logic [1:0] sz, input logic [1:0] p, input logic [31:0] d);
    st_en = 1'b1; st_way = w; st_set = s; st_offset = o;
    st_size = sz; st_bytepos = p; st_data = d;
  endtask

  task automatic store(input logic [0:0] w, input logic [6:0] s, input logic [2:0] o,
                       input logic [1:0] sz, input logic [1:0] p, input logic [31:0] d);
    set_store(w, s, o, sz, p, d);
    tick();
    st_en = 1'b0;
  endtask

  task automatic rd(input logic [6:0] s, input logic [2:0] o);
    rd_en = 1'b1; rd_set = s; rd_offset = o;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    fill_wvalid = 1'b1; fill_wdata = d; fill_wlast = last;
    tick();
    fill_wvalid = 1'b0; fill_wlast = 1'b0;
  endtask

  task automatic start_fill(input logic [0:0] w, input logic [6:0] s);
    fill_start = 1'b1; fill_way = w; fill_set = s;
    tick();
    fill_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; rd_set = '0; rd_offset = '0;
    st_en = 1'b0; st_way = '0; st_set = '0; st_offset = '0;
    st_size = '0; st_bytepos = '0; st_data = '0;
    fill_start = 1'b0; fill_way = '0; fill_set = '0;
    fill_wvalid = 1'b0; fill_wdata = '0; fill_wlast = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 64'h0);
    chk("rst_fill_busy", fill_busy, 0);
    chk("rst_fill_done", fill_done, 0);
    chk("rst_fill_err", fill_err, 0);
    chk("rst_fill_ready", fill_ready, 0);
    rst = 1'b0;
    #1;
    chk("idle_st_ready", st_ready, 1);

    // Preload words with full-word stores
    store(0, 5, 3, 2'b10, 2'b00, 32'hDEADBEEF);
    store(1, 5, 3, 2'b10, 2'b11, 32'h11223344);
    store(1, 5, 4, 2'b10, 2'b00, 32'hFFFFFFFF);
    store(1, 5, 5, 2'b10, 2'b00, 32'hFFFFFFFF);
    store(1, 5, 6, 2'b10, 2'b00, 32'h55555555);

    // Byte store pos 2
    store(1, 5, 3, 2'b00, 2'b10, 32'h00AB0000);
    rd(5, 3);
    chk("byte_rd_valid", rd_valid, 1);
    chk("byte_store", rd_data, {32'h11AB3344, 32'hDEADBEEF});
    tick();
    chk("rd_valid_drop", rd_valid, 0);
    chk("rd_data_hold", rd_data, {32'h11AB3344, 32'hDEADBEEF});

    // Three-byte pos 1 and half pos 3 (only lane 3 survives)
    store(1, 5, 4, 2'b11, 2'b01, 32'hAABBCC00);
    store(1, 5, 5, 2'b01, 2'b11, 32'h12345678);
    rd(5, 4);
    chk("tri_store", rd_data[63:32], 32'hAABBCCFF);
    rd(5, 5);
    chk("half_clip", rd_data[63:32], 32'h12FFFFFF);
    rd(5, 6);
    chk("neighbour", rd_data[63:32], 32'h55555555);

    // Fill way0/set9 with a bubble, stores interleaved
    start_fill(0, 9);
    chk("fill_busy", fill_busy, 1);
    chk("fill_ready", fill_ready, 1);
    for (int i = 0; i < 4; i++) beat(32'h100 + i, 1'b0);
    set_store(0, 9, 1, 2'b10, 2'b00, 32'hBAD00000);
    #1;
    chk("st_block_fill_line", st_ready, 0);
    set_store(0, 2, 0, 2'b10, 2'b00, 32'hCAFE0002);
    #1;
    chk("st_bubble_ready", st_ready, 1);
    tick();
    set_store(1, 3, 0, 2'b10, 2'b00, 32'h33333333);
    fill_wvalid = 1'b1; fill_wdata = 32'h104; fill_wlast = 1'b0;
    #1;
    chk("st_stall_beat", st_ready, 0);
    tick();
    fill_wvalid = 1'b0;
    #1;
    chk("st_retry_ready", st_ready, 1);
    tick();
    st_en = 1'b0;
    beat(32'h105, 1'b0);
    rd_en = 1'b1; rd_set = 9; rd_offset = 6;
    beat(32'h106, 1'b0);
    rd_en = 1'b0;
    chk("fill_bypass", rd_data[31:0], 32'h106);
    beat(32'h107, 1'b1);
    chk("fill_done", fill_done, 1);
    chk("fill_err_ok", fill_err, 0);
    tick();
    chk("fill_done_pulse", fill_done, 0);
    chk("fill_busy_clear", fill_busy, 0);
    st_way = 0; st_set = 9;
    #1;
    chk("st_ready_after", st_ready, 1);
    for (int i = 0; i < 8; i++) begin
      rd(9, 3'(i));
      chk($sformatf("fill_rb%0d", i), rd_data[31:0], 32'h100 + i);
    end
    rd(2, 0);
    chk("bubble_store", rd_data[31:0], 32'hCAFE0002);
    rd(3, 0);
    chk("stalled_store", rd_data[63:32], 32'h33333333);

    // Fill with misplaced wlast
    start_fill(1, 10);
    for (int i = 0; i < 8; i++) beat(32'h200 + i, i == 5);
    chk("err_done", fill_done, 1);
    chk("err_flag", fill_err, 1);
    tick();
    chk("err_pulse", fill_err, 0);
    rd(10, 7);
    chk("err_all_beats", rd_data[63:32], 32'h207);

    // Store with simultaneous read of the same word
    set_store(0, 5, 3, 2'b10, 2'b00, 32'h77778888);
    rd(5, 3);
    st_en = 1'b0;
    chk("bypass_word", rd_data, {32'h11AB3344, 32'h77778888});
    set_store(1, 5, 3, 2'b00, 2'b00, 32'h000000EE);
    rd(5, 3);
    st_en = 1'b0;
    chk("bypass_byte", rd_data, {32'h11AB33EE, 32'h77778888});

    // Reset mid-fill
    store(1, 20, 4, 2'b10, 2'b00, 32'h44440000);
    start_fill(1, 20);
    for (int i = 0; i < 4; i++) beat(32'h300 + i, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", fill_busy, 0);
    chk("rst_mid_done", fill_done, 0);
    tick();
    chk("rst_mid_no_done", fill_done, 0);
    for (int i = 0; i < 4; i++) begin
      rd(20, 3'(i));
      chk($sformatf("rst_keep%0d", i), rd_data[63:32], 32'h300 + i);
    end
    rd(20, 4);
    chk("rst_untouched", rd_data[63:32], 32'h44440000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_data_bank.md
Name: dcache_data_bank

Overview:
- Parametrised multi-way data array for the data cache; successor to the single-way, combinational-read data RAM.
- Holds NUM_WAYS x 2**SET_BITS lines of WORDS_PER_LINE 32-bit words.
- Provides a registered read of all ways, a byte-masked store port, and a line-refill sequencer that streams one burst from the bus interface into a chosen way.
- Sits between the dcache controller (tag compare, way select, miss FSM) and the AXI read-burst adapter.

Parameters:
- NUM_WAYS, 2, associativity (1..8).
- SET_BITS, 7, log2 of sets per way.
- WORDS_PER_LINE, 8, 32-bit words per line; power of two, 2..16.
- DATA_WIDTH, 32, word width; fixed 32, byte lanes = 4.
- WAY_BITS, $clog2(NUM_WAYS) min 1, derived.
- OFF_BITS, $clog2(WORDS_PER_LINE), derived.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- rd_en  in  1  read request.
- rd_set  in  SET_BITS  read set index.
- rd_offset  in  OFF_BITS  word within line.
- rd_valid  out  1  rd_data valid (rd_en delayed 1 cycle).
- rd_data  out  NUM_WAYS*32  word from every way, way 0 in [31:0].
- st_en  in  1  store request.
- st_ready  out  1  store accepted this cycle.
- st_way  in  WAY_BITS  target way.
- st_set  in  SET_BITS  target set.
- st_offset  in  OFF_BITS  target word.
- st_size  in  2  00 byte, 01 half, 10 word, 11 three bytes (SWL/SWR).
- st_bytepos  in  2  low address bits.
- st_data  in  32  lane-aligned store data.
- fill_start  in  1  begin refill (honoured only in IDLE).
- fill_way  in  WAY_BITS  refill way, latched at start.
- fill_set  in  SET_BITS  refill set, latched at start.
- fill_ready  out  1  high in FILL state.
- fill_wvalid  in  1  refill beat valid.
- fill_wdata  in  32  refill beat data.
- fill_wlast  in  1  bus marks last beat.
- fill_busy  out  1  FSM not IDLE.
- fill_done  out  1  one-cycle pulse, line complete.
- fill_err  out  1  one-cycle pulse with fill_done if wlast position was wrong.

Behaviour:
- Reset: FSM to IDLE; beat counter, rd_valid, rd_data, fill_done, fill_err, fill_busy all 0. Array contents are not cleared.
- Storage: one write port per way; NUM_WAYS banks of 2**SET_BITS*WORDS_PER_LINE words; byte write enables.

Read:
- rd_en at cycle N gives rd_valid=1 and rd_data at N+1. rd_data holds its value when rd_en=0.
- Write-first bypass: a write to the same way/set/offset in cycle N has its written bytes merged into rd_data at N+1. This applies to both store and fill writes.

Store mask:
- size 00: mask = 0001 << pos.
- size 01: mask = 0011 << pos.
- size 11: mask = 0111 << pos.
- size 10: mask = 1111, pos ignored.
- Bits shifted past lane 3 are dropped; never wrap into the next word.
- Bytes are written from the matching lanes of st_data.
- A store commits at the posedge when st_en && st_ready.

FSM IDLE -> FILL -> DONE -> IDLE:
- IDLE: fill_start latches way/set, clears counter, moves to FILL. st_ready=1.
- FILL: fill_ready=1. Each fill_wvalid beat writes fill_wdata at word counter with full mask, then counter++. The beat with counter==WORDS_PER_LINE-1 moves to DONE.
- DONE: fill_done=1 for one cycle, then IDLE.
- fill_err=1 in DONE if any beat had fill_wlast on a non-final beat, or the final beat lacked fill_wlast. Mismatch is recorded only; length is always WORDS_PER_LINE beats.
- fill_start outside IDLE is ignored.
- While fill_busy, st_ready=0 if st_set==latched set and st_way==latched way; otherwise st_ready=0 only in cycles with fill_wvalid=1 (fill owns the port). Refill beats always take priority and are never stalled.
- Read of the filling way/set during FILL returns current array content plus bypass; the controller must not hit on it until fill_done.
- rst mid-fill: immediate IDLE, no fill_done; words already written stay.
- Counter wraps modulo WORDS_PER_LINE; no overrun is possible.

Decomposition:
- Shared package dcache_pkg: store size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_TRI), fill FSM state enum, and function byte_mask(size,pos) -> 4-bit mask.
- Sub-module dcache_way_ram: one way, synchronous read, 4-lane byte-enable write. Instantiated NUM_WAYS times via generate.
- Top holds the FSM, arbitration and bypass mux.

Test Plan:
- Store at way1/set5/off3 with size 00, pos 2, data 0x00AB0000 over 0x11223344 -> read gives way1 word 0x11AB3344 one cycle after rd_en; way0 unchanged.
- Stores with size 11 pos 1 (data 0xAABBCC00) and size 01 pos 3 onto 0xFFFFFFFF -> results 0xAABBCCFF and 0xXXFFFFFF-style with only lane 3 written, and no neighbour-word change.
- Fill way0/set9, 8 beats 0x100..0x107 with a bubble after beat 3, wlast on beat 7 -> fill_done pulse 1 cycle after beat 7, fill_err=0, all offsets read back correctly.
- Same fill with wlast on beat 5 -> 8 beats still written, fill_err=1 with fill_done.
- Store to way0/set9 during fill -> st_ready=0 until DONE; store to set 2 lands in a bubble cycle; store with concurrent beat stalls one cycle.
- rd_en same cycle as a word store to the read address -> rd_data shows new value; rst asserted after fill beat 4 -> fill_busy=0 next cycle, no fill_done, words 0..3 retained.
